multicycle_uc: RTL and testbench
================================

# multicycle_uc

Multicycle control unit for the RV32I core. Sequences one shared ALU, one unified instruction/data memory port and the register file over several cycles per instruction, with a ready handshake that inserts memory wait states. Sits beside the multicycle datapath and replaces the single-cycle `UC` in that build. It reuses the existing ALU decoder for `aluControl`.

## Interface
Parameters:
- none; all encodings come from the shared package.

Ports:
- `clk`  in  1  — single clock; all state changes on its rising edge.
- `reset`  in  1  — asynchronous, active-low. Low forces state BOOT immediately.
- `op`  in  7  — opcode from the instruction register.
- `func3`  in  3  — func3 from the instruction register.
- `func7`  in  1  — instr[30].
- `zero`  in  1  — ALU zero flag.
- `memReady`  in  1  — memory completes the current access this cycle.
- `memReq`  out  1  — memory access requested.
- `adrSrc`  out  1  — 0 = PC, 1 = ALU result register.
- `memWrite`  out  1  — request is a store.
- `irWrite`  out  1  — load the instruction register and oldPC.
- `pcWrite`  out  1  — update PC; equals `pcUpdate | (branch & zero)`.
- `regWrite`  out  1  — register-file write.
- `resSrc`  out  2  — 00 = ALUOut, 01 = data register, 10 = ALU result.
- `aluSrcA`  out  2  — 00 = PC, 01 = oldPC, 10 = rs1.
- `aluSrcB`  out  2  — 00 = rs2, 01 = imm, 10 = constant 4.
- `aluControl`  out  3  — output of the existing ALU decoder.
- `immSrc`  out  2  — 00 = I, 01 = S, 10 = B, 11 = J. Decoded combinationally from `op`; 00 for unknown opcodes.
- `instret`  out  1  — one-cycle pulse in the final cycle of each retired instruction.
- `halted`  out  1  — high while in TRAP.

## Operation
- Moore FSM. All outputs are a function of the state, except that `irWrite`, `pcUpdate` and `instret` in memory states are qualified by `memReady`. Any signal not listed for a state is 0. `aluOp` is internal.
- BOOT: all outputs 0; goes to FETCH on the next edge.
- FETCH: `memReq`=1, `adrSrc`=0, `aluSrcA`=00, `aluSrcB`=10, `aluOp`=00, `resSrc`=10. `irWrite` and `pcUpdate` are asserted only with `memReady`. Holds until `memReady`, then goes to DECODE.
- DECODE: `aluSrcA`=01, `aluSrcB`=01, `aluOp`=00 (computes the branch target). Next state by opcode:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BEQ
  - 1101111 → JAL
  - anything else → TRAP
- MEMADR: `aluSrcA`=10, `aluSrcB`=01, `aluOp`=00. Goes to MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: `memReq`=1, `adrSrc`=1. Holds until `memReady`, then goes to MEMWB.
- MEMWB: `resSrc`=01, `regWrite`=1, `instret`=1. Goes to FETCH.
- MEMWRITE: `memReq`=1, `adrSrc`=1, `memWrite`=1, all held steady while waiting. `instret` pulses with `memReady`. Goes to FETCH on `memReady`.
- EXECR: `aluSrcA`=10, `aluSrcB`=00, `aluOp`=10. Goes to ALUWB.
- EXECI: `aluSrcA`=10, `aluSrcB`=01, `aluOp`=10. Goes to ALUWB.
- JAL: `aluSrcA`=01, `aluSrcB`=10, `aluOp`=00, `resSrc`=00, `pcUpdate`=1. Goes to ALUWB.
- ALUWB: `resSrc`=00, `regWrite`=1, `instret`=1. Goes to FETCH.
- BEQ: `aluSrcA`=10, `aluSrcB`=00, `aluOp`=01, `resSrc`=00, `branch`=1, `instret`=1. Goes to FETCH.
- TRAP: `halted`=1, all other outputs 0. Absorbing; only reset exits.

## Timing
- Cycles per instruction with zero wait states: lw 5, sw 4, R-type 4, I-type 4, jal 4, beq 3. Each wait cycle in FETCH, MEMREAD or MEMWRITE adds one.
- `memReady` is ignored outside memory states. `memReq` and `adrSrc` are stable for the whole access.
- BEQ: `pcWrite` = `zero` in that single cycle. `zero` is sampled in BEQ only.
- Reset mid-access: reset low while in MEMWRITE drops `memWrite` asynchronously. No partial write is acknowledged.
- Reset released: exactly one BOOT cycle, then the first FETCH.
- `op`, `func3` and `func7` need only be stable from DECODE to the end of the instruction, since the IR holds them.

## Structure
- Shared package `uc_pkg`:
  - state enum
  - opcode constants (LW, SW, RTYPE, ITYPE, BEQ, JAL)
  - encodings for `aluSrcA`, `aluSrcB`, `resSrc`, `immSrc` and `aluOp`
- Sub-module: the existing `aluDeco`, instantiated unchanged and driven by the internal `aluOp`.

## Test plan
- add x3,x1,x2 with `memReady` tied to 1 → states FETCH, DECODE, EXECR, ALUWB. `regWrite`=1 in cycle 4 only; `instret` pulses in cycle 4; `aluControl`=000 in EXECR.
- lw with `memReady` low for 2 cycles in both FETCH and MEMREAD → 9 cycles total. `irWrite` and `pcWrite` are a single pulse; `regWrite` appears in MEMWB only.
- beq with `zero`=1, then again with `zero`=0 → `pcWrite`=1 in BEQ for the first and 0 for the second; 3 cycles each.
- sw with reset asserted during the second MEMWRITE wait cycle → `memWrite` and `memReq` fall without waiting for a clock edge; after release, one BOOT cycle then FETCH.
- `op`=7'b1111111 → TRAP after DECODE. `halted`=1 with all other outputs 0 for 10+ cycles, regardless of `memReady`.
- jal → JAL asserts `pcWrite`; ALUWB writes PC+4 with `resSrc`=00. `immSrc`=11 throughout.

Source files
------------

// File: rtl/uc_pkg.sv
// Shared encodings for the multicycle control unit: states, opcodes, mux selects, ALU codes.
// Latency: n/a (types, constants and pure decode functions only).
// Backpressure: n/a.
package uc_pkg;

    typedef enum logic [3:0] {
        S_BOOT,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_JAL,
        S_ALUWB,
        S_BEQ,
        S_TRAP
    } state_t;

    // Opcodes this unit sequences
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    // ALU operand A select
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Result mux select
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // Immediate format select
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // ALU operation class handed to the ALU decoder
    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    // ALU control codes produced by the ALU decoder
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Per-state control word; pc_update and branch are combined into pcWrite at the top
    typedef struct packed {
        logic       mem_req;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       pc_update;
        logic       branch;
        logic       reg_write;
        logic [1:0] res_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       instret;
        logic       halted;
    } ctrl_t;

    // Moore output table: control word asserted while sitting in state s
    function automatic ctrl_t ctrl_of(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_req   = 1'b1;
                c.alu_src_a = SRCA_PC;
                c.alu_src_b = SRCB_FOUR;
                c.alu_op    = ALUOP_ADD;
                c.res_src   = RES_ALU;
                c.ir_write  = 1'b1;
                c.pc_update = 1'b1;
            end
            S_DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            S_MEMREAD: begin
                c.mem_req = 1'b1;
                c.adr_src = 1'b1;
            end
            S_MEMWB: begin
                c.res_src   = RES_DATA;
                c.reg_write = 1'b1;
                c.instret   = 1'b1;
            end
            S_MEMWRITE: begin
                c.mem_req   = 1'b1;
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
                c.instret   = 1'b1;
            end
            S_EXECR: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_RS2;
                c.alu_op    = ALUOP_FUNC;
            end
            S_EXECI: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_FUNC;
            end
            S_JAL: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_FOUR;
                c.alu_op    = ALUOP_ADD;
                c.res_src   = RES_ALUOUT;
                c.pc_update = 1'b1;
            end
            S_ALUWB: begin
                c.res_src   = RES_ALUOUT;
                c.reg_write = 1'b1;
                c.instret   = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_RS2;
                c.alu_op    = ALUOP_SUB;
                c.res_src   = RES_ALUOUT;
                c.branch    = 1'b1;
                c.instret   = 1'b1;
            end
            S_TRAP: begin
                c.halted = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

    // Immediate format from opcode; unknown opcodes fall back to I
    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        logic [1:0] imm;
        imm = IMM_I;
        case (op)
            OP_SW:   imm = IMM_S;
            OP_BEQ:  imm = IMM_B;
            OP_JAL:  imm = IMM_J;
            default: imm = IMM_I;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/multicycle_uc_alu_deco.sv
// ALU decoder: maps the ALU operation class plus func3/func7 to an ALU control code.
// Latency: purely combinational.
// Backpressure: none; follows its inputs.
module aluDeco
    import uc_pkg::*;
(
    input  logic       op_b5,
    input  logic [2:0] func3,
    input  logic       func7_b5,
    input  logic [1:0] alu_op,
    output logic [2:0] alu_control
);

    // Add for address/PC math, subtract for compare, otherwise decode the instruction function
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            default: begin
                case (func3)
                    3'b000:  alu_control = (op_b5 && func7_b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/multicycle_uc.sv
// Multicycle RV32I control unit sequencing a shared ALU, unified memory port and register file.
// Latency: 3-5 cycles per instruction plus one per memory wait cycle.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold until memReady; other states ignore it.
module multicycle_uc
    import uc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] func3,
    input  logic       func7,
    input  logic       zero,
    input  logic       memReady,
    output logic       memReq,
    output logic       adrSrc,
    output logic       memWrite,
    output logic       irWrite,
    output logic       pcWrite,
    output logic       regWrite,
    output logic [1:0] resSrc,
    output logic [1:0] aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [2:0] aluControl,
    output logic [1:0] immSrc,
    output logic       instret,
    output logic       halted
);

    state_t state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d;
    logic   mem_ok;
    logic   pc_update;

    // Next state, and the control word of that next state so outputs come straight from flops
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BOOT:     state_d = S_FETCH;
            S_FETCH:    state_d = memReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECR;
                    OP_ITYPE:     state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_TRAP;
                endcase
            end
            // Only lw/sw reach MEMADR; op[5] separates the store from the load
            S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = memReady ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = memReady ? S_FETCH : S_MEMWRITE;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_JAL:      state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_TRAP;
        endcase
        ctrl_d = ctrl_of(state_d);
    end

    // State and registered control word; reset clears both at once so a store drops immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_BOOT;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // In memory states the completing strobes wait for memReady; elsewhere they pass through
    assign mem_ok    = memReady | ~ctrl_q.mem_req;
    assign pc_update = ctrl_q.pc_update & mem_ok;

    assign memReq   = ctrl_q.mem_req;
    assign adrSrc   = ctrl_q.adr_src;
    assign memWrite = ctrl_q.mem_write;
    assign irWrite  = ctrl_q.ir_write & memReady;
    assign pcWrite  = pc_update | (ctrl_q.branch & zero);
    assign regWrite = ctrl_q.reg_write;
    assign resSrc   = ctrl_q.res_src;
    assign aluSrcA  = ctrl_q.alu_src_a;
    assign aluSrcB  = ctrl_q.alu_src_b;
    assign instret  = ctrl_q.instret & mem_ok;
    assign halted   = ctrl_q.halted;
    assign immSrc   = imm_src_of(op);

    aluDeco u_alu_deco (
        .op_b5       (op[5]),
        .func3       (func3),
        .func7_b5    (func7),
        .alu_op      (ctrl_q.alu_op),
        .alu_control (aluControl)
    );

endmodule

// File: tb/tb_multicycle_uc.sv
module tb_multicycle_uc;

    typedef struct packed {
        logic       mem_req;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] res_src;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [2:0] alu_ctl;
        logic [1:0] imm;
        logic       instret;
        logic       halted;
    } obs_t;

    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BEQ = 4, K_JAL = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] cur_op;
    logic [2:0] cur_f3;
    logic       cur_f7;
    logic       zero_in;
    logic       mem_ready;

    logic       memReq, adrSrc, memWrite, irWrite, pcWrite, regWrite, instret, halted;
    logic [1:0] resSrc, aluSrcA, aluSrcB, immSrc;
    logic [2:0] aluControl;

    int   checks = 0;
    int   errors = 0;
    obs_t exp_q[$];
    obs_t mon_e;
    obs_t obs;

    always #5 clk = ~clk;

    multicycle_uc dut (
        .clk        (clk),
        .reset      (rst_n),
        .op         (cur_op),
        .func3      (cur_f3),
        .func7      (cur_f7),
        .zero       (zero_in),
        .memReady   (mem_ready),
        .memReq     (memReq),
        .adrSrc     (adrSrc),
        .memWrite   (memWrite),
        .irWrite    (irWrite),
        .pcWrite    (pcWrite),
        .regWrite   (regWrite),
        .resSrc     (resSrc),
        .aluSrcA    (aluSrcA),
        .aluSrcB    (aluSrcB),
        .aluControl (aluControl),
        .immSrc     (immSrc),
        .instret    (instret),
        .halted     (halted)
    );

    assign obs = '{memReq, adrSrc, memWrite, irWrite, pcWrite, regWrite, resSrc,
                   aluSrcA, aluSrcB, aluControl, immSrc, instret, halted};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, want);
        end
    endtask

    // Scoreboard monitor: every cycle with a pending expectation is compared mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("cycle_outputs", 32'(obs), 32'(mon_e));
        end
    end

    // Reference: immediate format per RV32I opcode
    function automatic logic [1:0] ref_imm(input logic [6:0] o);
        case (o)
            7'b0100011: return 2'b01;
            7'b1100011: return 2'b10;
            7'b1101111: return 2'b11;
            default:    return 2'b00;
        endcase
    endfunction

    // Reference: ALU operation for an R/I arithmetic instruction
    function automatic logic [2:0] ref_alu(input bit is_r, input logic [2:0] f3, input logic f7);
        case (f3)
            3'b000:  return (is_r && f7) ? 3'b001 : 3'b000; // sub only for R-type with instr[30]
            3'b010:  return 3'b101;                         // slt
            3'b110:  return 3'b011;                         // or
            3'b111:  return 3'b010;                         // and
            default: return 3'b000;
        endcase
    endfunction

    function automatic obs_t quiet();
        obs_t e;
        e = '0;
        e.imm = ref_imm(cur_op);
        return e;
    endfunction

    function automatic obs_t fetch_e(input bit done);
        obs_t e;
        e = quiet();
        e.mem_req = 1'b1;
        e.src_b = 2'b10;
        e.res_src = 2'b10;
        e.ir_write = done;
        e.pc_write = done;
        return e;
    endfunction

    function automatic obs_t decode_e();
        obs_t e;
        e = quiet();
        e.src_a = 2'b01;
        e.src_b = 2'b01;
        return e;
    endfunction

    function automatic obs_t writeback_e(input logic [1:0] res);
        obs_t e;
        e = quiet();
        e.res_src = res;
        e.reg_write = 1'b1;
        e.instret = 1'b1;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit mr, input bit z, input obs_t e);
        mem_ready = mr;
        zero_in = z;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input bit mr, input bit z, input obs_t e);
        tick();
        drive(mr, z, e);
    endtask

    // Fetch with wf wait cycles after loading the new instruction fields
    task automatic do_fetch(input logic [6:0] o, input logic [2:0] f3, input logic f7, input int wf);
        tick();
        cur_op = o;
        cur_f3 = f3;
        cur_f7 = f7;
        if (wf == 0) begin
            drive(1'b1, 1'($urandom), fetch_e(1'b1));
        end else begin
            drive(1'b0, 1'($urandom), fetch_e(1'b0));
            for (int i = 1; i < wf; i++) cyc(1'b0, 1'($urandom), fetch_e(1'b0));
            cyc(1'b1, 1'($urandom), fetch_e(1'b1));
        end
        cyc(1'($urandom), 1'($urandom), decode_e());
    endtask

    task automatic run_instr(input int kind, input logic [2:0] f3, input logic f7,
                             input bit z, input int wf, input int wm);
        logic [6:0] o;
        obs_t e;
        case (kind)
            K_LW:    o = 7'b0000011;
            K_SW:    o = 7'b0100011;
            K_R:     o = 7'b0110011;
            K_I:     o = 7'b0010011;
            K_BEQ:   o = 7'b1100011;
            default: o = 7'b1101111;
        endcase
        do_fetch(o, f3, f7, wf);
        case (kind)
            K_LW, K_SW: begin
                e = quiet(); e.src_a = 2'b10; e.src_b = 2'b01;
                cyc(1'($urandom), 1'($urandom), e);
                e = quiet(); e.mem_req = 1'b1; e.adr_src = 1'b1; e.mem_write = (kind == K_SW);
                for (int i = 0; i < wm; i++) cyc(1'b0, 1'($urandom), e);
                e.instret = (kind == K_SW);
                cyc(1'b1, 1'($urandom), e);
                if (kind == K_LW) cyc(1'($urandom), 1'($urandom), writeback_e(2'b01));
            end
            K_R, K_I: begin
                e = quiet(); e.src_a = 2'b10; e.src_b = (kind == K_R) ? 2'b00 : 2'b01;
                e.alu_ctl = ref_alu(kind == K_R, f3, f7);
                cyc(1'($urandom), 1'($urandom), e);
                cyc(1'($urandom), 1'($urandom), writeback_e(2'b00));
            end
            K_BEQ: begin
                e = quiet(); e.src_a = 2'b10; e.alu_ctl = 3'b001;
                e.pc_write = z; e.instret = 1'b1;
                cyc(1'($urandom), z, e);
            end
            default: begin
                e = quiet(); e.src_a = 2'b01; e.src_b = 2'b10; e.pc_write = 1'b1;
                cyc(1'($urandom), 1'($urandom), e);
                cyc(1'($urandom), 1'($urandom), writeback_e(2'b00));
            end
        endcase
    endtask

    function automatic logic [2:0] pick_f3();
        logic [2:0] tbl [4];
        tbl = '{3'b000, 3'b010, 3'b110, 3'b111};
        return tbl[$urandom_range(0, 3)];
    endfunction

    initial begin
        obs_t e;
        rst_n = 1'b0;
        cur_op = 7'd0;
        cur_f3 = 3'd0;
        cur_f7 = 1'b0;
        zero_in = 1'b0;
        mem_ready = 1'b1;
        #3;
        check("reset_outputs", 32'(obs), 32'(quiet()));
        tick();
        tick();
        rst_n = 1'b1;
        drive(1'($urandom), 1'($urandom), quiet());   // the single BOOT cycle

        // Directed sequences
        run_instr(K_R, 3'b000, 1'b0, 1'b0, 0, 0);   // add
        run_instr(K_R, 3'b000, 1'b1, 1'b0, 0, 0);   // sub
        run_instr(K_LW, 3'b010, 1'b0, 1'b0, 2, 2);  // 9 cycles
        run_instr(K_BEQ, 3'b000, 1'b0, 1'b1, 0, 0);
        run_instr(K_BEQ, 3'b000, 1'b0, 1'b0, 0, 0);
        run_instr(K_JAL, 3'b000, 1'b0, 1'b0, 0, 0);
        run_instr(K_SW, 3'b010, 1'b0, 1'b0, 1, 1);

        // Store interrupted by reset during its second wait cycle
        do_fetch(7'b0100011, 3'b010, 1'b0, 0);
        e = quiet(); e.src_a = 2'b10; e.src_b = 2'b01;
        cyc(1'b1, 1'b0, e);
        e = quiet(); e.mem_req = 1'b1; e.adr_src = 1'b1; e.mem_write = 1'b1;
        cyc(1'b0, 1'b0, e);
        tick();
        mem_ready = 1'b0;
        check("sw_wait2_memWrite", 32'(memWrite), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_async_memWrite", 32'(memWrite), 32'd0);
        check("rst_async_memReq", 32'(memReq), 32'd0);
        check("rst_async_instret", 32'(instret), 32'd0);
        tick();
        check("rst_hold_outputs", 32'(obs), 32'(quiet()));
        rst_n = 1'b1;
        drive(1'($urandom), 1'($urandom), quiet());   // BOOT after release
        run_instr(K_I, 3'b000, 1'b1, 1'b0, 0, 0);     // addi ignores instr[30]

        // Randomized instruction mix with random wait states
        for (int n = 0; n < 60; n++) begin
            run_instr($urandom_range(0, 5), pick_f3(), 1'($urandom), 1'($urandom),
                      $urandom_range(0, 2), $urandom_range(0, 2));
        end

        // Unknown opcode traps permanently
        do_fetch(7'b1111111, 3'b000, 1'b0, 1);
        for (int i = 0; i < 12; i++) begin
            e = quiet(); e.halted = 1'b1;
            cyc(1'($urandom), 1'($urandom), e);
        end

        tick();
        tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
